cordic_step_stage: RTL and testbench

- One registered CORDIC micro-rotation stage: conditionally adds or subtracts shifted cross terms on an (x, y) vector and accumulates or removes one arctangent constant on an angle residual.
- N instances chained with SHIFT = 0..N-1 form a pipelined CORDIC, for example the sin/cos generator in rotation mode or a magnitude/atan block in vectoring mode.
- Latency is one clock per stage.

---
 rtl/cordic_step_stage_pkg.sv | 49 ++++
 rtl/cordic_step_stage_if.sv | 22 ++
 rtl/cordic_step_stage.sv | 96 +++++++++
 tb/tb_cordic_step_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cordic_step_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared constants and elaboration-time helpers for pipelined
//                CORDIC stages. These include the mode names, the arctangent
//                table generator and the CORDIC gain constant.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    localparam string CORDIC_ROTATION  = "rotation";
    localparam string CORDIC_VECTORING = "vectoring";

    localparam int    c_ATAN_TABLE_MAX = 32;
    localparam real   c_HALF_PI        = 1.5707963267948966;

    typedef int unsigned atan_table_t [c_ATAN_TABLE_MAX];

    // This function returns round(atan(2^-i) * 2^(aw-1) / (pi/2)).
    // Full scale 2^(aw-1) represents 90 degrees.
    function automatic int unsigned cordic_atan_entry(input int i, input int aw);
        real r_ang;
        r_ang = $atan($pow(2.0, -i)) * $pow(2.0, aw - 1) / c_HALF_PI;
        return int'($rtoi(r_ang + 0.5));
    endfunction

    // This function builds the default table for an n-stage chain.
    // Entries at or beyond n are left at zero.
    function automatic atan_table_t cordic_atan_table(input int n, input int aw);
        atan_table_t r_tbl;
        for (int i = 0; i < c_ATAN_TABLE_MAX; i++) begin
            r_tbl[i] = (i < n) ? cordic_atan_entry(i, aw) : 0;
        end
        return r_tbl;
    endfunction

    // This function returns the gain constant K = prod 1/sqrt(1 + 2^-2i),
    // scaled by 2^dw and rounded. For dw = 16 it gives 39797.
    function automatic int cordic_gain_k(input int dw);
        real r_k;
        r_k = 1.0;
        for (int i = 0; i < 40; i++) begin
            r_k = r_k / $sqrt(1.0 + $pow(2.0, -2 * i));
        end
        return $rtoi(r_k * $pow(2.0, dw) + 0.5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_step_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_step_stage_if
//  Description : Sample bus between CORDIC stages. It carries a qualifier,
//                the signed x/y vector and the signed angle.
//                master : drives valid, x, y, a
//                slave  : samples valid, x, y, a
//  Revision    : 1.0 - initial release
// ============================================================================
interface cordic_step_stage_if #(
    parameter int DW = 17,
    parameter int AW = 17
);
    logic                 valid;
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] y;
    logic signed [AW-1:0] a;

    modport master (output valid, x, y, a);
    modport slave  (input  valid, x, y, a);
endinterface
`default_nettype wire

// File: rtl/cordic_step_stage.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_step_stage
//  Description : One registered CORDIC micro-rotation stage.
//                (x, y) <- (x - d*(y>>>SHIFT), y + d*(x>>>SHIFT)),
//                a <- a - d*ATAN. The direction d comes from the angle sign
//                (rotation mode) or from the y sign (vectoring mode).
//  Ports       : clk_i  - clock, rising edge
//                rst_i  - synchronous active-high reset
//                s_in   - input sample bus (slave)
//                m_out  - output sample bus (master), one cycle latency
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_step_stage
    import cordic_pkg::*;
#(
    parameter int              DW    = 17,
    parameter int              AW    = 17,
    parameter int              SHIFT = 0,
    parameter logic [AW-1:0]   ATAN  = 32768,
    parameter string           MODE  = "rotation"
) (
    input  wire                        clk_i,
    input  wire                        rst_i,
    cordic_step_stage_if.slave         s_in,
    cordic_step_stage_if.master        m_out
);

    localparam bit c_IS_VECT = (MODE == CORDIC_VECTORING);

    generate
        if ((MODE != CORDIC_ROTATION) && (MODE != CORDIC_VECTORING)) begin : g_bad_mode
            $fatal(1, "cordic_step_stage: MODE must be \"rotation\" or \"vectoring\"");
        end
    endgenerate

    logic signed [DW-1:0] w_xs;
    logic signed [DW-1:0] w_ys;
    logic signed [DW-1:0] w_x_nxt;
    logic signed [DW-1:0] w_y_nxt;
    logic signed [AW-1:0] w_a_nxt;
    logic                 w_d_pos;

    logic                 r_valid;
    logic signed [DW-1:0] r_x;
    logic signed [DW-1:0] r_y;
    logic signed [AW-1:0] r_a;

    // Arithmetic shift replicates the sign. Large shifts collapse to 0 or -1.
    assign w_xs = s_in.x >>> SHIFT;
    assign w_ys = s_in.y >>> SHIFT;

    // Rotation drives the angle toward zero, and zero counts as positive.
    // Vectoring drives y toward zero, and y = 0 takes the d = -1 branch.
    assign w_d_pos = c_IS_VECT ? s_in.y[DW-1] : ~s_in.a[AW-1];

    // ATAN is non-negative. The result is kept modulo 2^AW, so AW-bit
    // arithmetic matches a zero-extended AW+1-bit sum after truncation.
    always_comb begin
        w_x_nxt = s_in.x;
        w_y_nxt = s_in.y;
        w_a_nxt = s_in.a;
        if (w_d_pos) begin
            w_x_nxt = s_in.x - w_ys;
            w_y_nxt = s_in.y + w_xs;
            w_a_nxt = s_in.a - $signed(ATAN);
        end else begin
            w_x_nxt = s_in.x + w_ys;
            w_y_nxt = s_in.y - w_xs;
            w_a_nxt = s_in.a + $signed(ATAN);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_a     <= '0;
        end else if (s_in.valid) begin
            r_valid <= 1'b1;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_a     <= w_a_nxt;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign m_out.valid = r_valid;
    assign m_out.x     = r_x;
    assign m_out.y     = r_y;
    assign m_out.a     = r_a;

endmodule
`default_nettype wire

// File: tb/tb_cordic_step_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_step_stage
//  Description : Self-checking bench for cordic_step_stage. Five stages share
//                one input bus: rotation SHIFT 0/1/2/20 and vectoring SHIFT 0.
//                Each stage is compared against an integer-arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_step_stage;

    localparam int c_DW  = 17;
    localparam int c_AW  = 17;
    localparam int c_NDUT = 5;

    localparam int c_SH [c_NDUT] = '{0, 1, 2, 0, 20};
    localparam int c_AT [c_NDUT] = '{32768, 19344, 9872, 32768, 5};
    localparam bit c_VM [c_NDUT] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    cordic_step_stage_if #(.DW(c_DW), .AW(c_AW)) in_if ();
    cordic_step_stage_if #(.DW(c_DW), .AW(c_AW)) o0_if ();
    cordic_step_stage_if #(.DW(c_DW), .AW(c_AW)) o1_if ();
    cordic_step_stage_if #(.DW(c_DW), .AW(c_AW)) o2_if ();
    cordic_step_stage_if #(.DW(c_DW), .AW(c_AW)) o3_if ();
    cordic_step_stage_if #(.DW(c_DW), .AW(c_AW)) o4_if ();

    cordic_step_stage #(.DW(c_DW), .AW(c_AW), .SHIFT(0), .ATAN(32768), .MODE("rotation"))
        u_rot0 (.clk_i(clk), .rst_i(rst), .s_in(in_if), .m_out(o0_if));
    cordic_step_stage #(.DW(c_DW), .AW(c_AW), .SHIFT(1), .ATAN(19344), .MODE("rotation"))
        u_rot1 (.clk_i(clk), .rst_i(rst), .s_in(in_if), .m_out(o1_if));
    cordic_step_stage #(.DW(c_DW), .AW(c_AW), .SHIFT(2), .ATAN(9872), .MODE("rotation"))
        u_rot2 (.clk_i(clk), .rst_i(rst), .s_in(in_if), .m_out(o2_if));
    cordic_step_stage #(.DW(c_DW), .AW(c_AW), .SHIFT(0), .ATAN(32768), .MODE("vectoring"))
        u_vec0 (.clk_i(clk), .rst_i(rst), .s_in(in_if), .m_out(o3_if));
    cordic_step_stage #(.DW(c_DW), .AW(c_AW), .SHIFT(20), .ATAN(5), .MODE("rotation"))
        u_rot20 (.clk_i(clk), .rst_i(rst), .s_in(in_if), .m_out(o4_if));

    logic                  w_ov [c_NDUT];
    logic signed [c_DW-1:0] w_ox [c_NDUT];
    logic signed [c_DW-1:0] w_oy [c_NDUT];
    logic signed [c_AW-1:0] w_oa [c_NDUT];

    assign w_ov[0] = o0_if.valid; assign w_ox[0] = o0_if.x; assign w_oy[0] = o0_if.y; assign w_oa[0] = o0_if.a;
    assign w_ov[1] = o1_if.valid; assign w_ox[1] = o1_if.x; assign w_oy[1] = o1_if.y; assign w_oa[1] = o1_if.a;
    assign w_ov[2] = o2_if.valid; assign w_ox[2] = o2_if.x; assign w_oy[2] = o2_if.y; assign w_oa[2] = o2_if.a;
    assign w_ov[3] = o3_if.valid; assign w_ox[3] = o3_if.x; assign w_oy[3] = o3_if.y; assign w_oa[3] = o3_if.a;
    assign w_ov[4] = o4_if.valid; assign w_ox[4] = o4_if.x; assign w_oy[4] = o4_if.y; assign w_oa[4] = o4_if.a;

    // Reference model state: the expected register contents per stage.
    longint e_v [c_NDUT];
    longint e_x [c_NDUT];
    longint e_y [c_NDUT];
    longint e_a [c_NDUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reduce to a w-bit two's-complement value.
    function automatic longint wrap(input longint v, input int w);
        longint p;
        longint m;
        p = longint'(1) << w;
        m = v % p;
        if (m < 0) m += p;
        if (m >= p / 2) m -= p;
        return m;
    endfunction

    // This function computes floor(v / 2^s) with plain arithmetic.
    function automatic longint floor_div_pow2(input longint v, input int s);
        longint p;
        p = longint'(1) << s;
        if (v >= 0) return v / p;
        return -((-v + p - 1) / p);
    endfunction

    task automatic model_update(input bit r, input bit v, input longint x,
                                input longint y, input longint a);
        longint xs, ys, d;
        for (int k = 0; k < c_NDUT; k++) begin
            if (r) begin
                e_v[k] = 0; e_x[k] = 0; e_y[k] = 0; e_a[k] = 0;
            end else if (v) begin
                xs = floor_div_pow2(x, c_SH[k]);
                ys = floor_div_pow2(y, c_SH[k]);
                if (c_VM[k]) d = (y < 0) ? 1 : -1;
                else         d = (a >= 0) ? 1 : -1;
                e_v[k] = 1;
                e_x[k] = wrap(x - d * ys, c_DW);
                e_y[k] = wrap(y + d * xs, c_DW);
                e_a[k] = wrap(a - d * longint'(c_AT[k]), c_AW);
            end else begin
                e_v[k] = 0;
            end
        end
    endtask

    task automatic check_all(input string phase);
        for (int k = 0; k < c_NDUT; k++) begin
            chk($sformatf("%s_d%0d_valid", phase, k), longint'(w_ov[k]), e_v[k]);
            chk($sformatf("%s_d%0d_x", phase, k), longint'(w_ox[k]), e_x[k]);
            chk($sformatf("%s_d%0d_y", phase, k), longint'(w_oy[k]), e_y[k]);
            chk($sformatf("%s_d%0d_a", phase, k), longint'(w_oa[k]), e_a[k]);
        end
    endtask

    // Drive one cycle of input away from the edge, clock it and compare.
    task automatic step(input string phase, input bit r, input bit v,
                        input longint x, input longint y, input longint a);
        @(negedge clk);
        rst         = r;
        in_if.valid = v;
        in_if.x     = x[c_DW-1:0];
        in_if.y     = y[c_DW-1:0];
        in_if.a     = a[c_AW-1:0];
        @(posedge clk);
        model_update(r, v, x, y, a);
        #1;
        check_all(phase);
    endtask

    initial begin
        longint rx, ry, ra;
        bit     rv, rr;
        n_checks = 0;
        n_errors = 0;
        rst         = 1'b1;
        in_if.valid = 1'b0;
        in_if.x     = '0;
        in_if.y     = '0;
        in_if.a     = '0;
        for (int k = 0; k < c_NDUT; k++) begin
            e_v[k] = 0; e_x[k] = 0; e_y[k] = 0; e_a[k] = 0;
        end

        step("reset", 1, 0, 0, 0, 0);
        step("reset2", 1, 1, 123, 456, 789);

        // Directed vectors. Hand-derived values are checked explicitly too.
        step("rot_pos", 0, 1, 39797, 0, 1000);
        chk("tp_rot_pos_x", longint'(w_ox[0]), 39797);
        chk("tp_rot_pos_y", longint'(w_oy[0]), 39797);
        chk("tp_rot_pos_a", longint'(w_oa[0]), -31768);

        step("rot_neg", 0, 1, 100, -50, -5);
        chk("tp_rot_neg_x", longint'(w_ox[1]), 75);
        chk("tp_rot_neg_y", longint'(w_oy[1]), -100);
        chk("tp_rot_neg_a", longint'(w_oa[1]), 19339);

        step("shift_neg", 0, 1, 10, -7, 0);
        chk("tp_shift_x", longint'(w_ox[2]), 12);
        chk("tp_shift_y", longint'(w_oy[2]), -5);
        chk("tp_shift_a", longint'(w_oa[2]), -9872);

        step("vec_pos", 0, 1, 100, 60, 0);
        chk("tp_vec_pos_x", longint'(w_ox[3]), 160);
        chk("tp_vec_pos_y", longint'(w_oy[3]), -40);
        chk("tp_vec_pos_a", longint'(w_oa[3]), 32768);

        step("vec_neg", 0, 1, 100, -60, 0);
        chk("tp_vec_neg_x", longint'(w_ox[3]), 160);
        chk("tp_vec_neg_y", longint'(w_oy[3]), 40);
        chk("tp_vec_neg_a", longint'(w_oa[3]), -32768);

        step("vec_y0", 0, 1, 100, 0, 7);

        step("wrap", 0, 1, 65535, 65535, 1);
        chk("tp_wrap_x", longint'(w_ox[0]), 0);
        chk("tp_wrap_y", longint'(w_oy[0]), -2);

        // Hold for three idle cycles.
        step("hold0", 0, 0, 1, 2, 3);
        step("hold1", 0, 0, -4, 5, -6);
        step("hold2", 0, 0, 7, -8, 9);
        chk("tp_hold_valid", longint'(w_ov[0]), 0);
        chk("tp_hold_y", longint'(w_oy[0]), -2);

        step("pre_rst", 0, 1, 300, 200, 100);
        step("rst_valid", 1, 1, 300, 200, 100);
        chk("tp_rst_x", longint'(w_ox[0]), 0);

        // Back-to-back samples.
        step("b2b0", 0, 1, 1000, -2000, 3000);
        step("b2b1", 0, 1, -1000, 2000, -3000);
        step("b2b2", 0, 1, 65535, -65536, -65536);
        step("b2b3", 0, 1, -65536, 65535, 65535);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            rr = ($urandom_range(0, 31) == 0);
            rv = ($urandom_range(0, 3) != 0);
            rx = longint'($urandom_range(0, 131071)) - 65536;
            ry = longint'($urandom_range(0, 131071)) - 65536;
            ra = longint'($urandom_range(0, 131071)) - 65536;
            step("rand", rr, rv, rx, ry, ra);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
